// File: rtl/vliw_mem_pkg.sv
// Shared defaults and state encoding for the VLIW MEM-stage load/store unit.
package vliw_mem_pkg;

  localparam int ADDR_W_DEF  = 22;
  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 5;
  localparam int MAX_OUT_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_tag_fifo.sv
// Tag FIFO holding destination tags of loads awaiting read data.
import vliw_mem_pkg::*;

module lsu_tag_fifo #(
  parameter int DEPTH = MAX_OUT_DEF,
  parameter int WIDTH = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  a_no_ovf: assert property (
    @(posedge clk) disable iff (rst) !(push && full));
  a_no_udf: assert property (
    @(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: req/gnt issue, in-order rvalid return,
// tagged load responses with up to MAX_OUT loads in flight.
import vliw_mem_pkg::*;

module mem_lsu #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_we,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic [TAG_W-1:0]  op_tag,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              store_done,
  output logic              busy,
  output logic              err_unexpected
);

  localparam int CW = $clog2(MAX_OUT + 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic              sdone_q, sdone_d;
  logic              err_q, err_d;

  logic              accept, push, pop;
  logic              fifo_empty, fifo_full;
  logic [TAG_W-1:0]  fifo_dout;

  always_comb begin
    op_ready = ((state_q == IDLE) | ((state_q == REQ) & mem_gnt))
             & (cnt_q < CW'(MAX_OUT));
    accept   = op_valid & op_ready;
    push     = accept & ~op_we;
    pop      = mem_rvalid & (cnt_q != '0);

    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_gnt) state_d = accept ? REQ : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      we_d    = op_we;
      addr_d  = op_addr;
      wdata_d = op_wdata;
    end

    // Load slot is reserved at accept so the FIFO can never overflow.
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rv_d    = pop;
    rdata_d = pop ? mem_rdata : rdata_q;
    rtag_d  = pop ? fifo_dout : rtag_q;
    sdone_d = (state_q == REQ) & mem_gnt & we_q;
    err_d   = err_q | (mem_rvalid & (cnt_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      rtag_q  <= '0;
      sdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
      sdone_q <= sdone_d;
      err_q   <= err_d;
    end
  end

  lsu_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (op_tag),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign mem_req        = (state_q == REQ);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign resp_valid     = rv_q;
  assign resp_data      = rdata_q;
  assign resp_tag       = rtag_q;
  assign store_done     = sdone_q;
  assign busy           = (state_q == REQ) | (cnt_q != '0);
  assign err_unexpected = err_q;

  a_cnt_fifo: assert property (@(posedge clk) disable iff (rst)
    (fifo_full == (cnt_q == CW'(MAX_OUT))) &&
    (fifo_empty == (cnt_q == '0)));

endmodule
